// File: rtl/dpram_arbiter_pkg.sv
// dpram_arbiter_pkg: shared widths, requester-ID type and one-hot helper for dpram_arbiter.
// Revision 1.0 - initial release
`default_nettype none

package dpram_arbiter_pkg;

   localparam int AW       = 10;
   localparam int DW       = 8;
   localparam int MAX_NREQ = 4;

   typedef logic [1:0] req_id_t;

   function automatic req_id_t oh2id(input logic [MAX_NREQ-1:0] oh);
      req_id_t id;
      id = '0;
      for (int i = 0; i < MAX_NREQ; i++) begin
         if (oh[i]) id = req_id_t'(i);
      end
      return id;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_arbiter_rr_arbiter.sv
// rr_arbiter: NREQ-wide round-robin picker with one-hot grant and pointer register.
// Macro DPRAM_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority instead.  Revision 1.0
`default_nettype none

module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NREQ-1:0] req_i,
   input  logic            en_i,
   output logic [NREQ-1:0] pick_o,
   output logic [NREQ-1:0] gnt_o
);

`ifdef DPRAM_ARBITER_FIXED_PRIO_EN
   logic unused_clk_rst;
   assign unused_clk_rst = clk_i ^ rst_i;

   always_comb begin
      pick_o = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            pick_o    = '0;
            pick_o[i] = 1'b1;
         end
      end
   end
`else
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;
   logic [IDW-1:0] pick_id;
   logic [IDW-1:0] cand;
   logic           found;

   // Walk the ring starting at the pointer; the first asserted request wins.
   always_comb begin
      pick_o  = '0;
      pick_id = '0;
      found   = 1'b0;
      cand    = ptr_q;
      for (int s = 0; s < NREQ; s++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!found && req_i[j] && (cand == IDW'(j))) begin
               found     = 1'b1;
               pick_o[j] = 1'b1;
               pick_id   = IDW'(j);
            end
         end
         cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (|gnt_o) ptr_d = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`endif

   assign gnt_o = en_i ? pick_o : '0;

endmodule

`default_nettype wire

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: independent write/read arbitration of NREQ requesters onto one dpram_1024x8.
// Macro DPRAM_ARBITER_FIXED_PRIO_EN switches both ports to fixed priority.  Revision 1.0
`default_nettype none

module dpram_arbiter
   import dpram_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic               CK,
   input  logic               RST,
   input  logic [NREQ-1:0]    wr_req,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]    wr_gnt,
   input  logic [NREQ-1:0]    rd_req,
   input  logic [NREQ*AW-1:0] rd_addr,
   output logic [NREQ-1:0]    rd_gnt,
   output logic [NREQ-1:0]    rd_valid,
   output logic [DW-1:0]      rd_data,
   output logic [AW-1:0]      waddr,
   output logic [AW-1:0]      raddr,
   output logic [DW-1:0]      data_in,
   output logic               wen,
   output logic               ren,
   output logic               mem_clk,
   input  logic [DW-1:0]      data_out
);

   logic [NREQ-1:0] wr_pick;
   logic [NREQ-1:0] rd_pick;
   logic [AW-1:0]   wr_win_addr;
   logic [DW-1:0]   wr_win_data;
   logic [AW-1:0]   rd_win_addr;
   logic            collide;
   logic            rd_en;

   logic [AW-1:0]   waddr_q;
   logic [AW-1:0]   raddr_q;
   logic [DW-1:0]   data_in_q;
   logic            rd_pend_q;
   logic            rd_pend_d;
   logic [IDW-1:0]  rd_id_q;
   logic [IDW-1:0]  rd_id_d;

   assign mem_clk = CK;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_wr_arb (
      .clk_i  (CK),
      .rst_i  (RST),
      .req_i  (wr_req),
      .en_i   (~RST),
      .pick_o (wr_pick),
      .gnt_o  (wr_gnt)
   );

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rd_arb (
      .clk_i  (CK),
      .rst_i  (RST),
      .req_i  (rd_req),
      .en_i   (rd_en),
      .pick_o (rd_pick),
      .gnt_o  (rd_gnt)
   );

   always_comb begin
      wr_win_addr = '0;
      wr_win_data = '0;
      rd_win_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (wr_pick[i]) begin
            wr_win_addr = wr_addr[i*AW +: AW];
            wr_win_data = wr_data[i*DW +: DW];
         end
         if (rd_pick[i]) rd_win_addr = rd_addr[i*AW +: AW];
      end
   end

   // A read that hits the address being written this cycle waits one cycle so it sees the new data.
   assign wen     = |wr_gnt;
   assign collide = wen && (|rd_pick) && (rd_win_addr == wr_win_addr);
   assign rd_en   = ~RST && ~collide;
   assign ren     = |rd_gnt;

   always_comb begin
      waddr   = waddr_q;
      data_in = data_in_q;
      raddr   = raddr_q;
      if (RST) begin
         waddr   = '0;
         data_in = '0;
         raddr   = '0;
      end else begin
         if (wen) begin
            waddr   = wr_win_addr;
            data_in = wr_win_data;
         end
         if (ren) raddr = rd_win_addr;
      end
   end

   assign rd_pend_d = ren;
   assign rd_id_d   = IDW'(oh2id(MAX_NREQ'(rd_gnt)));

   always_ff @(posedge CK) begin
      if (RST) begin
         waddr_q   <= '0;
         raddr_q   <= '0;
         data_in_q <= '0;
         rd_pend_q <= 1'b0;
         rd_id_q   <= '0;
      end else begin
         waddr_q   <= waddr;
         raddr_q   <= raddr;
         data_in_q <= data_in;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
      end
   end

   always_comb begin
      rd_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         rd_valid[i] = rd_pend_q && ~RST && (rd_id_q == IDW'(i));
      end
   end

   assign rd_data = (|rd_valid) ? data_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: directed self-checking bench for dpram_arbiter with a behavioural dpram_1024x8.
// Revision 1.0
`default_nettype none

module tb_dpram_arbiter;

   logic        CK = 1'b0;
   logic        RST;
   logic [1:0]  wr_req, rd_req;
   logic [19:0] wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_gnt, rd_gnt, rd_valid;
   logic [7:0]  rd_data, data_in, data_out;
   logic [9:0]  waddr, raddr;
   logic        wen, ren, mem_clk;

   logic [7:0]  mem [1024];
   int          tests_run = 0;
   int          tests_failed = 0;

   always #5 CK = ~CK;

   dpram_arbiter #(.NREQ(2), .IDW(2)) dut (
      .CK(CK), .RST(RST),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .waddr(waddr), .raddr(raddr), .data_in(data_in),
      .wen(wen), .ren(ren), .mem_clk(mem_clk), .data_out(data_out)
   );

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      data_out = 8'h00;
   end

   always @(posedge mem_clk) begin
      if (wen) mem[waddr] <= data_in;
      if (ren) data_out <= mem[raddr];
   end

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; wr_req = 2'b00; rd_req = 2'b00;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; wr_req = 2'b11; rd_req = 2'b11;
      wr_addr = {10'h155, 10'h0AA}; rd_addr = {10'h123, 10'h321}; wr_data = 16'h3C7E;
      for (int c = 0; c < 3; c++) begin
         tick(); #3;
         tests_run++;
         if ({wr_gnt, rd_gnt, wen, ren, rd_valid} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl cyc%0d: wr_gnt=%b rd_gnt=%b wen=%b ren=%b rd_valid=%b, want all 0",
                     c, wr_gnt, rd_gnt, wen, ren, rd_valid);
         end
         tests_run++;
         if ({rd_data, waddr, raddr, data_in} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_data cyc%0d: rd_data=%h waddr=%h raddr=%h data_in=%h, want 0",
                     c, rd_data, waddr, raddr, data_in);
         end
      end
      RST = 1'b0; rd_req = 2'b00;
      #3;
      tests_run++;
      if (wr_gnt !== 2'b01) begin
         tests_failed++;
         $display("FAIL reset_first_wr_gnt: got %b, want 01", wr_gnt);
      end
      wr_req = 2'b00;
   endtask

   task automatic test_rr_fairness();
      logic [1:0] exp_seq [6];
`ifdef DPRAM_ARBITER_FIXED_PRIO_EN
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
      do_reset();
      wr_req = 2'b11; wr_addr = {10'h200, 10'h100}; wr_data = 16'h2211;
      for (int c = 0; c < 6; c++) begin
         #3;
         tests_run++;
         if (wr_gnt !== exp_seq[c]) begin
            tests_failed++;
            $display("FAIL rr_wr_gnt cyc%0d: got %b, want %b", c, wr_gnt, exp_seq[c]);
         end
         tick();
      end
      wr_req = 2'b00;
   endtask

   task automatic test_round_trip();
      do_reset();
      wr_req = 2'b01; wr_addr = {10'h000, 10'h3FF}; wr_data = 16'h00A5;
      #3;
      tests_run++;
      if ({wr_gnt, wen, waddr, data_in} !== {2'b01, 1'b1, 10'h3FF, 8'hA5}) begin
         tests_failed++;
         $display("FAIL rt_write: wr_gnt=%b wen=%b waddr=%h data_in=%h, want 01 1 3ff a5",
                  wr_gnt, wen, waddr, data_in);
      end
      tick();
      wr_req = 2'b00; wr_addr = 20'h0; wr_data = 16'h0;
      #3;
      tests_run++;
      if ({wen, waddr, data_in} !== {1'b0, 10'h3FF, 8'hA5}) begin
         tests_failed++;
         $display("FAIL rt_hold: wen=%b waddr=%h data_in=%h, want 0 3ff a5", wen, waddr, data_in);
      end
      tick();
      rd_req = 2'b10; rd_addr = {10'h3FF, 10'h000};
      #3;
      tests_run++;
      if ({rd_gnt, ren, raddr, rd_valid} !== {2'b10, 1'b1, 10'h3FF, 2'b00}) begin
         tests_failed++;
         $display("FAIL rt_rd_gnt: rd_gnt=%b ren=%b raddr=%h rd_valid=%b, want 10 1 3ff 00",
                  rd_gnt, ren, raddr, rd_valid);
      end
      tick();
      rd_req = 2'b00;
      #3;
      tests_run++;
      if ({rd_valid, rd_data} !== {2'b10, 8'hA5}) begin
         tests_failed++;
         $display("FAIL rt_rd_data: rd_valid=%b rd_data=%h, want 10 a5", rd_valid, rd_data);
      end
      tick(); #3;
      tests_run++;
      if ({rd_valid, rd_data, ren} !== 11'h0) begin
         tests_failed++;
         $display("FAIL rt_idle: rd_valid=%b rd_data=%h ren=%b, want 0", rd_valid, rd_data, ren);
      end
   endtask

   task automatic test_collision();
      do_reset();
      wr_req = 2'b01; wr_addr = {10'h000, 10'h010}; wr_data = 16'h005C;
      rd_req = 2'b10; rd_addr = {10'h010, 10'h000};
      #3;
      tests_run++;
      if ({wr_gnt, rd_gnt, ren} !== {2'b01, 2'b00, 1'b0}) begin
         tests_failed++;
         $display("FAIL col_suppress: wr_gnt=%b rd_gnt=%b ren=%b, want 01 00 0", wr_gnt, rd_gnt, ren);
      end
      tick();
      wr_req = 2'b00;
      #3;
      tests_run++;
      if ({rd_gnt, ren, raddr} !== {2'b10, 1'b1, 10'h010}) begin
         tests_failed++;
         $display("FAIL col_retry: rd_gnt=%b ren=%b raddr=%h, want 10 1 010", rd_gnt, ren, raddr);
      end
      tick();
      rd_req = 2'b00;
      #3;
      tests_run++;
      if ({rd_valid, rd_data} !== {2'b10, 8'h5C}) begin
         tests_failed++;
         $display("FAIL col_data: rd_valid=%b rd_data=%h, want 10 5c", rd_valid, rd_data);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_gnt [4];
`ifdef DPRAM_ARBITER_FIXED_PRIO_EN
      exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      do_reset();
      rd_req = 2'b11; rd_addr = {10'h010, 10'h3FF};
      for (int c = 0; c < 4; c++) begin
         #3;
         tests_run++;
         if (rd_gnt !== exp_gnt[c]) begin
            tests_failed++;
            $display("FAIL b2b_rd_gnt cyc%0d: got %b, want %b", c, rd_gnt, exp_gnt[c]);
         end
         if (c > 0) begin
            tests_run++;
            if (rd_valid !== exp_gnt[c-1]) begin
               tests_failed++;
               $display("FAIL b2b_rd_valid cyc%0d: got %b, want %b", c, rd_valid, exp_gnt[c-1]);
            end
         end
         tick();
      end
      rd_req = 2'b00;
      #3;
      tests_run++;
      if (rd_valid !== exp_gnt[3] || rd_data !== (exp_gnt[3] == 2'b01 ? 8'hA5 : 8'h5C)) begin
         tests_failed++;
         $display("FAIL b2b_last_beat: rd_valid=%b rd_data=%h, want %b", rd_valid, rd_data, exp_gnt[3]);
      end
      tick();
   endtask

   task automatic test_mid_read_reset();
      do_reset();
      rd_req = 2'b01; rd_addr = {10'h000, 10'h3FF}; RST = 1'b1;
      #3;
      tests_run++;
      if ({rd_gnt, ren} !== 3'b000) begin
         tests_failed++;
         $display("FAIL mrr_gnt_in_rst: rd_gnt=%b ren=%b, want 00 0", rd_gnt, ren);
      end
      tick();
      RST = 1'b0; rd_req = 2'b00;
      #3;
      tests_run++;
      if ({rd_valid, rd_data} !== 10'h0) begin
         tests_failed++;
         $display("FAIL mrr_valid_after: rd_valid=%b rd_data=%h, want 0", rd_valid, rd_data);
      end
      tick();
      rd_req = 2'b01;
      #3;
      tests_run++;
      if (rd_gnt !== 2'b01) begin
         tests_failed++;
         $display("FAIL mrr_pre_gnt: rd_gnt=%b, want 01", rd_gnt);
      end
      tick();
      RST = 1'b1; rd_req = 2'b00;
      #3;
      tests_run++;
      if ({rd_valid, rd_data} !== 10'h0) begin
         tests_failed++;
         $display("FAIL mrr_valid_in_rst: rd_valid=%b rd_data=%h, want 0", rd_valid, rd_data);
      end
      tick();
      RST = 1'b0;
      #3;
      tests_run++;
      if (rd_valid !== 2'b00) begin
         tests_failed++;
         $display("FAIL mrr_valid_post: rd_valid=%b, want 00", rd_valid);
      end
   endtask

   initial begin
      RST = 1'b1; wr_req = 2'b00; rd_req = 2'b00;
      wr_addr = 20'h0; rd_addr = 20'h0; wr_data = 16'h0;
      test_reset();
      test_rr_fairness();
      test_round_trip();
      test_collision();
      test_back_to_back();
      test_mid_read_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
